// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and data load/store.
// Data has priority; a fetch wins whenever the previous grant went to data.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ip_inst_req,
    input  logic [ADDR_WIDTH-1:0]   ip_inst_addr,
    output logic                    op_inst_valid,
    output logic [DATA_WIDTH-1:0]   op_inst_data,
    input  logic                    ip_data_rd,
    input  logic                    ip_data_wr,
    input  logic [ADDR_WIDTH-1:0]   ip_data_addr,
    input  logic [DATA_WIDTH/8-1:0] ip_data_mask,
    input  logic [DATA_WIDTH-1:0]   ip_data_wdata,
    output logic                    op_data_valid,
    output logic [DATA_WIDTH-1:0]   op_data_rdata,
    output logic                    op_mem_req,
    output logic [ADDR_WIDTH-1:0]   op_mem_addr,
    output logic                    op_mem_wr,
    output logic [DATA_WIDTH/8-1:0] op_mem_mask,
    output logic [DATA_WIDTH-1:0]   op_mem_wdata,
    input  logic                    ip_mem_ready,
    input  logic                    ip_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   ip_mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWNER_INST, OWNER_DATA} owner_t;

    state_t state;
    owner_t owner;
    logic   last_was_data;
    logic   data_pending;
    logic   grant_inst;

    always_comb begin
        data_pending = ip_data_rd | ip_data_wr;
        grant_inst   = ip_inst_req & (last_was_data | ~data_pending);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= OWNER_INST;
            last_was_data <= 1'b0;
            op_inst_valid <= 1'b0;
            op_inst_data  <= '0;
            op_data_valid <= 1'b0;
            op_data_rdata <= '0;
            op_mem_req    <= 1'b0;
            op_mem_addr   <= '0;
            op_mem_wr     <= 1'b0;
            op_mem_mask   <= '0;
            op_mem_wdata  <= '0;
        end else begin
            op_inst_valid <= 1'b0;
            op_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_inst) begin
                        op_mem_addr   <= ip_inst_addr;
                        op_mem_wr     <= 1'b0;
                        op_mem_mask   <= '1;
                        op_mem_wdata  <= '0;
                        owner         <= OWNER_INST;
                        last_was_data <= 1'b0;
                        op_mem_req    <= 1'b1;
                        state         <= ISSUE;
                    end else if (data_pending) begin
                        // rd and wr together resolve to a store
                        op_mem_addr   <= ip_data_addr;
                        op_mem_wr     <= ip_data_wr;
                        op_mem_mask   <= ip_data_wr ? ip_data_mask : '1;
                        op_mem_wdata  <= ip_data_wdata;
                        owner         <= OWNER_DATA;
                        last_was_data <= 1'b1;
                        op_mem_req    <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ip_mem_ready) begin
                        op_mem_req <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (ip_mem_rvalid) begin
                        if (owner == OWNER_INST) begin
                            op_inst_valid <= 1'b1;
                            op_inst_data  <= ip_mem_rdata;
                        end else begin
                            op_data_valid <= 1'b1;
                            if (!op_mem_wr) op_data_rdata <= ip_mem_rdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scripted memory responder plus per-scenario
// tasks that compare observed port behaviour against hand-computed values.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        data_rd;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_mask;
    logic [31:0] data_wdata;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    // observations recorded by mem_txn
    logic        t_timeout;
    int          t_wait;
    logic [31:0] t_addr;
    logic        t_wr;
    logic [3:0]  t_mask;
    logic [31:0] t_wdata;
    int          t_req_cycles;
    logic        t_stable;
    logic        t_req_after;
    logic        t_inst_v;
    logic        t_data_v;
    logic [31:0] t_inst_data;
    logic [31:0] t_data_rdata;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .ip_inst_req   (inst_req),
        .ip_inst_addr  (inst_addr),
        .op_inst_valid (inst_valid),
        .op_inst_data  (inst_data),
        .ip_data_rd    (data_rd),
        .ip_data_wr    (data_wr),
        .ip_data_addr  (data_addr),
        .ip_data_mask  (data_mask),
        .ip_data_wdata (data_wdata),
        .op_data_valid (data_valid),
        .op_data_rdata (data_rdata),
        .op_mem_req    (mem_req),
        .op_mem_addr   (mem_addr),
        .op_mem_wr     (mem_wr),
        .op_mem_mask   (mem_mask),
        .op_mem_wdata  (mem_wdata),
        .ip_mem_ready  (mem_ready),
        .ip_mem_rvalid (mem_rvalid),
        .ip_mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_rd    = 1'b0;
        data_wr    = 1'b0;
        data_addr  = '0;
        data_mask  = '0;
        data_wdata = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Memory responder: waits for a request, holds ready low for ready_delay cycles,
    // returns rvalid the cycle after acceptance, and stops in the valid-pulse cycle.
    task automatic mem_txn(input int ready_delay, input logic [31:0] rdata);
        t_timeout = 1'b1;
        t_wait    = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            t_wait++;
            if (mem_req) begin
                t_timeout = 1'b0;
                break;
            end
        end
        if (t_timeout) return;
        t_addr       = mem_addr;
        t_wr         = mem_wr;
        t_mask       = mem_mask;
        t_wdata      = mem_wdata;
        t_req_cycles = 0;
        t_stable     = 1'b1;
        for (int i = 0; i <= ready_delay; i++) begin
            if (mem_req) t_req_cycles++;
            if (mem_addr !== t_addr || mem_wr !== t_wr || mem_mask !== t_mask || mem_wdata !== t_wdata)
                t_stable = 1'b0;
            mem_ready = (i == ready_delay);
            tick();
        end
        mem_ready   = 1'b0;
        t_req_after = mem_req;
        mem_rvalid  = 1'b1;
        mem_rdata   = rdata;
        tick();
        mem_rvalid   = 1'b0;
        t_inst_v     = inst_valid;
        t_data_v     = data_valid;
        t_inst_data  = inst_data;
        t_data_rdata = data_rdata;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
        tests++; if (mem_mask !== 4'h0) begin fails++; $display("FAIL reset_mem_mask: got %0h want 0", mem_mask); end
        tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
        tests++; if (inst_valid !== 1'b0 || data_valid !== 1'b0) begin fails++; $display("FAIL reset_valids: got %0h/%0h want 0/0", inst_valid, data_valid); end
    endtask

    task automatic test_fetch_only();
        inst_req  = 1'b1;
        inst_addr = 32'h4;
        mem_txn(0, 32'h00A00093);
        tests++; if (t_timeout !== 1'b0) begin fails++; $display("FAIL fetch_timeout: got %0h want 0", t_timeout); end
        tests++; if (t_wait != 1) begin fails++; $display("FAIL fetch_req_latency: got %0d want 1", t_wait); end
        tests++; if (t_addr !== 32'h4 || t_wr !== 1'b0 || t_mask !== 4'hF) begin fails++; $display("FAIL fetch_fields: got addr %0h wr %0h mask %0h want 4/0/f", t_addr, t_wr, t_mask); end
        tests++; if (t_req_cycles != 1 || t_req_after !== 1'b0) begin fails++; $display("FAIL fetch_req_len: got %0d cycles, after %0h want 1, 0", t_req_cycles, t_req_after); end
        tests++; if (t_inst_v !== 1'b1 || t_inst_data !== 32'h00A00093) begin fails++; $display("FAIL fetch_resp: got v %0h data %0h want 1 a00093", t_inst_v, t_inst_data); end
        tests++; if (t_data_v !== 1'b0) begin fails++; $display("FAIL fetch_data_valid: got %0h want 0", t_data_v); end
        inst_req = 1'b0;
        tick();
        tests++; if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL fetch_pulse_end: got v %0h req %0h want 0 0", inst_valid, mem_req); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_addr;
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'h200;
        data_rd   = 1'b1;
        data_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            mem_txn(0, (i % 2 == 0) ? (32'hD000_0000 + i) : (32'h1000_0000 + i));
            exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
            tests++; if (t_timeout !== 1'b0 || t_addr !== exp_addr) begin fails++; $display("FAIL alt_grant_%0d: got addr %0h timeout %0h want %0h", i, t_addr, t_timeout, exp_addr); end
            if (i % 2 == 0) begin
                tests++; if (t_data_v !== 1'b1 || t_inst_v !== 1'b0 || t_data_rdata !== 32'hD000_0000 + i) begin fails++; $display("FAIL alt_resp_%0d: got dv %0h iv %0h rdata %0h want 1 0 %0h", i, t_data_v, t_inst_v, t_data_rdata, 32'hD000_0000 + i); end
            end else begin
                tests++; if (t_inst_v !== 1'b1 || t_data_v !== 1'b0 || t_inst_data !== 32'h1000_0000 + i) begin fails++; $display("FAIL alt_resp_%0d: got iv %0h dv %0h data %0h want 1 0 %0h", i, t_inst_v, t_data_v, t_inst_data, 32'h1000_0000 + i); end
            end
            if (i == 3) begin
                inst_req = 1'b0;
                data_rd  = 1'b0;
            end
            tick();
            tests++; if (inst_valid !== 1'b0 || data_valid !== 1'b0) begin fails++; $display("FAIL alt_idle_%0d: got %0h/%0h want 0/0", i, inst_valid, data_valid); end
        end
    endtask

    task automatic test_store_backpressure();
        data_wr    = 1'b1;
        data_addr  = 32'h8;
        data_mask  = 4'h3;
        data_wdata = 32'hDEADBEEF;
        mem_txn(3, 32'h1234_5678);
        tests++; if (t_timeout !== 1'b0 || t_req_cycles != 4 || t_stable !== 1'b1) begin fails++; $display("FAIL store_req_hold: got %0d cycles stable %0h want 4 1", t_req_cycles, t_stable); end
        tests++; if (t_addr !== 32'h8 || t_wr !== 1'b1 || t_mask !== 4'h3 || t_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL store_fields: got %0h %0h %0h %0h want 8 1 3 deadbeef", t_addr, t_wr, t_mask, t_wdata); end
        tests++; if (t_data_v !== 1'b1 || t_inst_v !== 1'b0) begin fails++; $display("FAIL store_valid: got dv %0h iv %0h want 1 0", t_data_v, t_inst_v); end
        tests++; if (t_data_rdata !== 32'hD000_0002) begin fails++; $display("FAIL store_rdata_kept: got %0h want d0000002", t_data_rdata); end
        data_wr = 1'b0;
        tick();
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL store_single_pulse: got %0h want 0", data_valid); end
    endtask

    task automatic test_spurious();
        mem_rvalid = 1'b1;
        mem_ready  = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || data_valid !== 1'b0) begin fails++; $display("FAIL spurious_%0d: got req %0h iv %0h dv %0h want 0 0 0", i, mem_req, inst_valid, data_valid); end
        end
        mem_rvalid = 1'b0;
        mem_ready  = 1'b0;
        inst_req   = 1'b1;
        inst_addr  = 32'h10;
        mem_txn(0, 32'h0000_0013);
        tests++; if (t_timeout !== 1'b0 || t_wait != 1 || t_inst_v !== 1'b1 || t_inst_data !== 32'h13) begin fails++; $display("FAIL spurious_then_fetch: got wait %0d v %0h data %0h want 1 1 13", t_wait, t_inst_v, t_inst_data); end
        inst_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        inst_req  = 1'b1;
        inst_addr = 32'h40;
        tick();
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL mid_issue: got req %0h want 1", mem_req); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        inst_req  = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_mask !== 4'h0 || inst_data !== 32'h0 || data_rdata !== 32'h0) begin fails++; $display("FAIL mid_reset_outputs: got req %0h addr %0h mask %0h idata %0h drdata %0h want all 0", mem_req, mem_addr, mem_mask, inst_data, data_rdata); end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++; if (inst_valid !== 1'b0 || data_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL mid_late_rvalid_%0d: got iv %0h dv %0h req %0h want 0 0 0", i, inst_valid, data_valid, mem_req); end
            tick();
        end
        inst_req  = 1'b1;
        inst_addr = 32'h44;
        mem_txn(0, 32'h0040_0093);
        tests++; if (t_timeout !== 1'b0 || t_addr !== 32'h44 || t_inst_v !== 1'b1 || t_inst_data !== 32'h0040_0093) begin fails++; $display("FAIL mid_next_fetch: got addr %0h v %0h data %0h want 44 1 400093", t_addr, t_inst_v, t_inst_data); end
        inst_req = 1'b0;
        tick();
    endtask

    task automatic test_rd_wr_both();
        data_rd    = 1'b1;
        data_wr    = 1'b1;
        data_addr  = 32'hC;
        data_mask  = 4'hF;
        data_wdata = 32'h0000_55AA;
        mem_txn(0, 32'h7777_7777);
        tests++; if (t_timeout !== 1'b0 || t_wr !== 1'b1 || t_mask !== 4'hF || t_wdata !== 32'h55AA) begin fails++; $display("FAIL rdwr_is_write: got wr %0h mask %0h wdata %0h want 1 f 55aa", t_wr, t_mask, t_wdata); end
        tests++; if (t_data_v !== 1'b1 || t_data_rdata !== 32'h0) begin fails++; $display("FAIL rdwr_resp: got v %0h rdata %0h want 1 0", t_data_v, t_data_rdata); end
        data_rd = 1'b0;
        data_wr = 1'b0;
        tick();
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL rdwr_single_pulse: got %0h want 0", data_valid); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_store_backpressure();
        test_spurious();
        test_reset_mid();
        test_rd_wr_both();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
